gpio_debounce: RTL

Input-conditioning stage between the SoC input pads and the `gpio` peripheral's `gpio_i` port. It synchronises each pad bit, debounces it with a programmable prescaled stability counter, and drives the clean level to `gpio`. It also detects rising and falling edges on the debounced level and latches per-bit interrupt status with a single level interrupt output. It has its own register window, using the same register-interface signalling as `gpio`.

---
 rtl/gpio_debounce_if.sv | 25 ++
 rtl/gpio_debounce.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/gpio_debounce_if.sv
// Register-window signalling shared with the gpio peripheral.
// The master drives address/data/strobes; the slave returns combinational read data.
interface gpio_debounce_if;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        we_i;
  logic        re_i;
  logic [31:0] rdata_o;

  modport master (
    output addr_i,
    output wdata_i,
    output we_i,
    output re_i,
    input  rdata_o
  );

  modport slave (
    input  addr_i,
    input  wdata_i,
    input  we_i,
    input  re_i,
    output rdata_o
  );
endinterface

// File: rtl/gpio_debounce.sv
// Pad input conditioning: two-flop synchroniser, prescaled per-bit debounce,
// edge detection with W1C status latching and a single level interrupt.
module gpio_debounce #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  gpio_debounce_if.slave   reg_if,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic             irq_o
);

  localparam logic [4:0] ADDR_PRESCALE = 5'h00;
  localparam logic [4:0] ADDR_THRESH   = 5'h04;
  localparam logic [4:0] ADDR_RISE_EN  = 5'h08;
  localparam logic [4:0] ADDR_FALL_EN  = 5'h0C;
  localparam logic [4:0] ADDR_STATUS   = 5'h10;
  localparam logic [4:0] ADDR_LEVEL    = 5'h14;
  localparam logic [3:0] THRESH_RST    = 4'd4;

  logic [WIDTH-1:0]      sync1_q, sync1_d;
  logic [WIDTH-1:0]      sync2_q, sync2_d;
  logic [PRE_W-1:0]      prescale_q, prescale_d;
  logic [PRE_W-1:0]      pre_cnt_q, pre_cnt_d;
  logic [3:0]            thresh_q, thresh_d;
  logic [WIDTH-1:0]      rise_en_q, rise_en_d;
  logic [WIDTH-1:0]      fall_en_q, fall_en_d;
  logic [WIDTH-1:0]      status_q, status_d;
  logic [WIDTH-1:0]      deb_q, deb_d;
  logic [WIDTH-1:0][3:0] cnt_q, cnt_d;

  logic                  wr_prescale_s;
  logic                  wr_thresh_s;
  logic                  wr_rise_en_s;
  logic                  wr_fall_en_s;
  logic                  wr_status_s;
  logic                  tick_s;
  logic [WIDTH-1:0]      set_s;
  logic [WIDTH-1:0]      clr_s;
  logic [31:0]           rdata_s;
  logic                  unused_s;

  // Address decode of the write strobe; only the low five address bits matter
  always_comb begin
    wr_prescale_s = 1'b0;
    wr_thresh_s   = 1'b0;
    wr_rise_en_s  = 1'b0;
    wr_fall_en_s  = 1'b0;
    wr_status_s   = 1'b0;
    if (reg_if.we_i) begin
      case (reg_if.addr_i[4:0])
        ADDR_PRESCALE: wr_prescale_s = 1'b1;
        ADDR_THRESH:   wr_thresh_s   = 1'b1;
        ADDR_RISE_EN:  wr_rise_en_s  = 1'b1;
        ADDR_FALL_EN:  wr_fall_en_s  = 1'b1;
        ADDR_STATUS:   wr_status_s   = 1'b1;
        default:       wr_prescale_s = 1'b0;
      endcase
    end else begin
      wr_prescale_s = 1'b0;
    end
  end

  // Software-visible configuration registers
  always_comb begin
    prescale_d = prescale_q;
    thresh_d   = thresh_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    if (wr_prescale_s) prescale_d = reg_if.wdata_i[PRE_W-1:0];
    else               prescale_d = prescale_q;
    if (wr_thresh_s)   thresh_d   = reg_if.wdata_i[3:0];
    else               thresh_d   = thresh_q;
    if (wr_rise_en_s)  rise_en_d  = reg_if.wdata_i[WIDTH-1:0];
    else               rise_en_d  = rise_en_q;
    if (wr_fall_en_s)  fall_en_d  = reg_if.wdata_i[WIDTH-1:0];
    else               fall_en_d  = fall_en_q;
  end

  // Two-stage synchroniser on the raw pads
  always_comb begin
    sync1_d = pad_i;
    sync2_d = sync1_q;
  end

  // Free-running prescaler; a PRESCALE write restarts it so the new period is clean
  always_comb begin
    tick_s = (pre_cnt_q == prescale_q);
    if (wr_prescale_s) begin
      pre_cnt_d = '0;
    end else if (tick_s) begin
      pre_cnt_d = '0;
    end else begin
      pre_cnt_d = pre_cnt_q + PRE_W'(1);
    end
  end

  // Per-bit stability counter: flip only after THRESH mismatched ticks, zero means bypass
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (thresh_q == 4'd0) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = 4'd0;
      end else if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = 4'd0;
      end else if (tick_s) begin
        if (({1'b0, cnt_q[i]} + 5'd1) >= {1'b0, thresh_q}) begin
          deb_d[i] = sync2_q[i];
          cnt_d[i] = 4'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Edge-triggered status set with W1C clear; a same-cycle set overrides the clear
  always_comb begin
    set_s = (~deb_q & deb_d & rise_en_q) | (deb_q & ~deb_d & fall_en_q);
    if (wr_status_s) clr_s = reg_if.wdata_i[WIDTH-1:0];
    else             clr_s = '0;
    status_d = (status_q & ~clr_s) | set_s;
  end

  // Combinational read mux, forced to zero when no read is in progress
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (reg_if.re_i) begin
      case (reg_if.addr_i[4:0])
        ADDR_PRESCALE: rdata_s[PRE_W-1:0] = prescale_q;
        ADDR_THRESH:   rdata_s[3:0]       = thresh_q;
        ADDR_RISE_EN:  rdata_s[WIDTH-1:0] = rise_en_q;
        ADDR_FALL_EN:  rdata_s[WIDTH-1:0] = fall_en_q;
        ADDR_STATUS:   rdata_s[WIDTH-1:0] = status_q;
        ADDR_LEVEL:    rdata_s[WIDTH-1:0] = deb_q;
        default:       rdata_s            = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  // State flops; reset drops everything to its idle value at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      thresh_q   <= THRESH_RST;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      status_q   <= '0;
      deb_q      <= '0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      thresh_q   <= thresh_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      status_q   <= status_d;
      deb_q      <= deb_d;
      cnt_q      <= cnt_d;
    end
  end

  assign reg_if.rdata_o = rdata_s;
  assign gpio_o         = deb_q;
  assign irq_o          = |status_q;

  // Upper address bits and write-data bits above the register widths are ignored
  assign unused_s = ^{reg_if.addr_i[31:5], reg_if.wdata_i};

endmodule
